// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam logic [15:0] DEF_DIV_DEF = 16'h0402;
  localparam int unsigned MIN_DIV     = 2;

  // Number of high cycles in a period of n input clocks: ceil(n/2).
  function automatic int unsigned high_count(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow ratio pair, registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(MIN_DIV)
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             resync_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clkout_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             shd_ok;
  logic             at_end;

  // Shadow ratio is runnable; counter sits on the last cycle of its period.
  assign shd_ok = (shd_q >= CNT_W'(MIN_DIV));
  assign at_end = (cnt_q == act_q - CNT_W'(1));

  // Next-state: disable > resync/start > period boundary > count; a load then overrides the shadow.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    run_d  = run_q;
    pend_d = pend_q;
    if (!en_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (resync_i || !run_q || at_end) begin
      // Start, resync and boundary all apply the pre-edge shadow and begin a fresh period.
      act_d  = shd_q;
      pend_d = 1'b0;
      run_d  = shd_ok;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load_i) begin
      shd_d  = div_i;
      pend_d = 1'b1;
    end
  end

  // Outputs are decoded from next state so they line up with the registered counter.
  always_comb begin
    clk_d  = run_d && (32'(cnt_d) < high_count(32'(act_d)));
    tick_d = run_d && (cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      shd_q  <= RST_DIV;
      run_q  <= 1'b0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      run_q  <= run_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clkout_o = clk_q;
  assign tick_o   = tick_q;
  assign pend_o   = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels sharing resync.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned              NUM_CH  = 2,
  parameter int unsigned              CNT_W   = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]  DEF_DIV = (NUM_CH*CNT_W)'(DEF_DIV_DEF)
) (
  input  logic                    clkin,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       clkout,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  // One channel per output bit; ratio buses sliced CNT_W bits per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEF_DIV[i*CNT_W +: CNT_W])
    ) u_chan (
      .clkin    (clkin),
      .reset_n  (reset_n),
      .en_i     (ch_en[i]),
      .load_i   (div_load[i]),
      .resync_i (resync),
      .div_i    (div_in[i*CNT_W +: CNT_W]),
      .clkout_o (clkout[i]),
      .tick_o   (tick[i]),
      .pend_o   (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: per-channel expected {clkout,tick,pending} streams.
module tb_clk_div_multi;

  logic        clkin = 1'b0;
  logic        reset_n;
  logic [1:0]  ch_en;
  logic [15:0] div_in;
  logic [1:0]  div_load;
  logic        resync;
  logic [1:0]  clkout;
  logic [1:0]  tick;
  logic [1:0]  pending;

  int checks = 0;
  int fails  = 0;
  logic [2:0] e0[$];
  logic [2:0] e1[$];
  logic [5:0] exp_v;

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(16'h0402)) dut (
    .clkin    (clkin),
    .reset_n  (reset_n),
    .ch_en    (ch_en),
    .div_in   (div_in),
    .div_load (div_load),
    .resync   (resync),
    .clkout   (clkout),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clkin = ~clkin;

  function automatic logic [5:0] obs();
    return {clkout[1], tick[1], pending[1], clkout[0], tick[0], pending[0]};
  endfunction

  // Expected samples for cnt running k0, k0+1, ... under ratio n: high for ceil(n/2), tick at 0.
  function automatic void push_run(input int ch, input int n, input int k0, input int cnt, input logic p);
    for (int i = 0; i < cnt; i++) begin
      int k;
      logic [2:0] v;
      k = (k0 + i) % n;
      v = {1'(k < (n + 1) / 2), 1'(k == 0), p};
      if (ch == 0) e0.push_back(v);
      else e1.push_back(v);
    end
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; ch_en = 2'b11; div_in = '0; div_load = '0; resync = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    checks++;
    if (obs() !== 6'b0) begin
      fails++;
      $display("FAIL reset_state got=%b exp=%b", obs(), 6'b0);
    end
    @(negedge clkin);
    reset_n = 1'b1;
  endtask

  task automatic test_defaults();
    push_run(0, 2, 0, 8, 1'b0);
    push_run(1, 4, 0, 8, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL defaults c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_odd_ratio();
    e0.push_back(3'b110);
    e0.push_back(3'b001);
    push_run(0, 3, 0, 9, 1'b0);
    push_run(1, 4, 0, 11, 1'b0);
    div_in = {8'd0, 8'd3};
    for (int c = 0; c < 11; c++) begin
      div_load = (c == 1) ? 2'b01 : 2'b00;
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL odd_ratio c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
    div_load = '0;
  endtask

  task automatic test_load_boundary();
    push_run(0, 3, 0, 17, 1'b0);
    push_run(1, 4, 3, 1, 1'b0);
    push_run(1, 4, 0, 4, 1'b1);
    push_run(1, 6, 0, 12, 1'b0);
    div_in = {8'd6, 8'd0};
    for (int c = 0; c < 17; c++) begin
      div_load = (c == 1) ? 2'b10 : 2'b00;
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL load_boundary c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
    div_load = '0;
  endtask

  task automatic test_halt_restart();
    e0.push_back(3'b001);
    repeat (3) e0.push_back(3'b000);
    e0.push_back(3'b001);
    push_run(0, 5, 0, 10, 1'b0);
    push_run(1, 6, 0, 15, 1'b0);
    for (int c = 0; c < 15; c++) begin
      div_in   = (c == 0) ? {8'd0, 8'd1} : {8'd0, 8'd5};
      div_load = (c == 0 || c == 4) ? 2'b01 : 2'b00;
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL halt_restart c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
    div_load = '0;
  endtask

  task automatic test_resync();
    push_run(0, 5, 0, 5, 1'b1);
    push_run(0, 3, 0, 5, 1'b0);
    push_run(0, 3, 0, 12, 1'b0);
    push_run(1, 6, 3, 3, 1'b1);
    push_run(1, 4, 0, 7, 1'b0);
    push_run(1, 4, 0, 12, 1'b0);
    div_in = {8'd4, 8'd3};
    for (int c = 0; c < 22; c++) begin
      div_load = (c == 0) ? 2'b11 : 2'b00;
      resync   = (c == 10);
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL resync c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
    div_load = '0;
    resync   = 1'b0;
  endtask

  task automatic test_async_reset();
    push_run(0, 3, 0, 2, 1'b0);
    push_run(1, 4, 0, 2, 1'b1);
    div_in = {8'd7, 8'd0};
    for (int c = 0; c < 2; c++) begin
      div_load = (c == 0) ? 2'b10 : 2'b00;
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL pre_reset c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
    div_load = '0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 6'b0) begin
      fails++;
      $display("FAIL async_reset_immediate got=%b exp=%b", obs(), 6'b0);
    end
    repeat (2) @(posedge clkin);
    #1;
    checks++;
    if (obs() !== 6'b0) begin
      fails++;
      $display("FAIL async_reset_held got=%b exp=%b", obs(), 6'b0);
    end
    @(negedge clkin);
    reset_n = 1'b1;
    push_run(0, 2, 0, 8, 1'b0);
    push_run(1, 4, 0, 8, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL post_reset c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
  endtask

  task automatic test_enable();
    push_run(0, 2, 0, 10, 1'b0);
    e1.push_back(3'b000);
    repeat (3) e1.push_back(3'b001);
    push_run(1, 3, 0, 6, 1'b0);
    div_in = {8'd3, 8'd0};
    for (int c = 0; c < 10; c++) begin
      ch_en    = (c < 4) ? 2'b01 : 2'b11;
      resync   = (c == 0);
      div_load = (c == 1) ? 2'b10 : 2'b00;
      @(posedge clkin); #1;
      exp_v = {e1.pop_front(), e0.pop_front()};
      checks++;
      if (obs() !== exp_v) begin
        fails++;
        $display("FAIL enable c=%0d got=%b exp=%b", c, obs(), exp_v);
      end
    end
    div_load = '0;
    resync   = 1'b0;
    ch_en    = 2'b11;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_odd_ratio();
    test_load_boundary();
    test_halt_restart();
    test_resync();
    test_async_reset();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable clock divider, the parametrised successor to the fixed two-output top-level divider. Generates NUM_CH divided clocks plus per-channel period ticks from one input clock. Each channel has a runtime-loadable ratio with glitch-free shadow update at period boundaries, odd-ratio support, per-channel enable, and a global phase resync. Sits at the top-level clocking layer, feeding slow-clock and enable consumers.

Parameters:
NUM_CH, 2, number of output channels (1..8)
CNT_W, 8, counter/ratio width; max ratio 2^CNT_W-1
DEF_DIV, 16'h0402, flat NUM_CH*CNT_W reset ratios; slice i = channel i (default ch0=2, ch1=4)

Ports:
clkin  in  1  input clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
ch_en  in  NUM_CH  per-channel run enable
div_in  in  NUM_CH*CNT_W  new ratios; slice i for channel i
div_load  in  NUM_CH  per-channel strobe: capture div_in slice into shadow
resync  in  1  restart all enabled channels in phase
clkout  out  NUM_CH  divided clocks, registered
tick  out  NUM_CH  1-cycle pulse on first cycle of each period
pending  out  NUM_CH  shadow written, not yet applied

Behaviour:
- Per-channel state: cnt[CNT_W], div_act, div_shd, run, pend. All outputs are flops; no combinational paths to outputs.
- Reset (async, immediate): cnt=0, run=0, div_act=div_shd=DEF_DIV slice, pend=0, clkout=0, tick=0.
- Let N=div_act, H=ceil(N/2). In any cycle with run=1 and cnt=k: clkout=1 iff k<H; tick=1 iff k==0. Duty: H high, N-H low (N=3 -> 2 high, 1 low).
- Start: edge with run=0 and ch_en=1: div_act<=div_shd, pend<=0; if div_shd>=2 then run<=1, cnt<=0 (clkout=1, tick=1 after that edge), i.e. 1-cycle latency from enable; otherwise stay halted, outputs 0.
- Running edge: cnt==N-1 -> cnt<=0 (boundary): div_act<=div_shd, pend<=0, and the new period uses the new N. Otherwise cnt<=cnt+1.
- Applied ratio <2 (0 or 1): at that boundary run<=0, cnt<=0, outputs 0. Channel restarts via the Start rule once a valid ratio is loaded, so 2 edges after div_load.
- div_load edge: div_shd<=div_in slice, pend<=1, accepted in any state. The boundary/start/resync on the same edge uses the pre-edge div_shd. The newly loaded value waits for the next boundary and pend stays 1.
- ch_en=0 at edge: run<=0, cnt<=0, clkout<=0, tick<=0; div_shd and pend retained.
- resync=1 at edge: highest priority below reset, applies to all channels with ch_en=1. Each is treated as Start (apply pre-edge shadow, cnt<=0, tick=1 if ratio valid) regardless of cnt. Channels with ch_en=0 are unaffected.
- Reset mid-operation: all state returns to reset values immediately, including loaded shadows.
- No glitches: clkout changes only on clkin rising edges, and never shows a period shorter than the lesser of old H and new H around a ratio change.

Decomposition:
- Package clk_div_pkg: CNT_W default, DEF_DIV default, function high_count(N) returning ceil(N/2), and constant MIN_DIV=2.
- Sub-module clk_div_chan: one channel (cnt, div_act, div_shd, run, pend, clkout, tick). clk_div_multi instantiates it NUM_CH times in a generate loop and slices the buses.

Test Plan:
1. Defaults: ch_en=2'b11, release reset -> clkout0 1,0,1,0..., clkout1 1,1,0,0..., tick1 every 4th cycle, pending=0.
2. Odd ratio: load 3 into ch0 at cnt=0 of its period -> pending0=1 for 1 cycle, then clkout0 1,1,0 repeating, tick0 every 3 cycles.
3. Load on boundary edge: load 6 into ch1 on the edge where cnt1 3->0 -> old ratio 4 runs one more period, then 3 high/3 low; pending1 high for exactly 4 cycles.
4. Halt/restart: load 1 into ch0 -> at boundary clkout0=0, tick0=0; then load 5 -> clkout0 resumes 2 edges later, 3 high/2 low.
5. Resync: ch0=3, ch1=4 out of phase, pulse resync -> tick0 and tick1 both high on the next cycle, then periods 3 and 4 from that point.
6. Async reset mid-run after loading 7 into ch1: drop reset_n between edges -> clkout/tick/pending 0 immediately; on release ch1 runs at ratio 4.
